// File: rtl/seg_pkg.sv
// Shared types and constants for the four-digit seven-segment display path.
package seg_pkg;

  localparam int NUM_DIGITS      = 4;
  localparam int DIGIT_W         = 4;
  localparam int CLK_DIV_DEFAULT = 100000;

  typedef logic [1:0]                    digit_sel_t;
  typedef logic [NUM_DIGITS*DIGIT_W-1:0] bcd4_t;

  function automatic logic [NUM_DIGITS-1:0] onehot_sel(input digit_sel_t sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Free-running clock divider: tick is high for one cycle out of every CLK_DIV.
module seg_prescaler
  import seg_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Digit-scan scheduler with frame-synchronous double-buffered BCD value.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits above DP_DIGIT.
module seg_scan_scheduler
  import seg_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEFAULT,
  parameter int DP_DIGIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  bcd4_t                 value_in,
  input  logic                  load,
  input  logic                  enable,
  output digit_sel_t            cnt,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [DIGIT_W-1:0]    digit,
  output logic                  point,
  output logic                  frame_done,
  output logic                  pending
);

  localparam digit_sel_t DP_SEL = digit_sel_t'(DP_DIGIT);

  logic                  tick;
  logic                  boundary;
  bcd4_t                 display;
  bcd4_t                 pend_buf;
  logic [NUM_DIGITS-1:0] lit;

  seg_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign boundary = tick && (cnt == digit_sel_t'(NUM_DIGITS - 1));

  // A load in the boundary cycle bypasses the buffer so the newest value wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      display    <= '0;
      pend_buf   <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (tick) begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        pend_buf <= value_in;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          display <= value_in;
        end else if (pending) begin
          display <= pend_buf;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit stays lit if it sits at/below the decimal point or anything from it upward is nonzero.
  always_comb begin
    lit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lit[k] = (k <= DP_DIGIT) || ((display >> (DIGIT_W * k)) != '0);
    end
  end
`else
  assign lit = '1;
`endif

  always_comb begin
    digit = display[cnt*DIGIT_W +: DIGIT_W];
    AN    = (enable && lit[cnt]) ? onehot_sel(cnt) : '0;
    point = enable && lit[cnt] && (cnt == DP_SEL);
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler with CLK_DIV=4, DP_DIGIT=1; a cycle model feeds a scoreboard queue.
module tb_seg_scan_scheduler;

  localparam int DIV = 4;
  localparam int DP  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic        load;
  logic        enable;
  logic [1:0]  cnt;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        point;
  logic        frame_done;
  logic        pending;

  always #5 clk = ~clk;

  seg_scan_scheduler #(.CLK_DIV(DIV), .DP_DIGIT(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .load       (load),
    .enable     (enable),
    .cnt        (cnt),
    .AN         (an),
    .digit      (digit),
    .point      (point),
    .frame_done (frame_done),
    .pending    (pending)
  );

  typedef struct {
    logic [1:0] cnt;
    logic [3:0] an;
    logic [3:0] digit;
    logic       point;
    logic       fd;
    logic       pend;
  } exp_t;

  typedef struct {
    logic       en;
    logic [1:0] cnt;
    logic [3:0] an;
    logic [3:0] digit;
    logic       point;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;

  // Reference state: scan position is derived from the cycle count since reset.
  int          m_cyc;
  logic [15:0] m_disp;
  logic [15:0] m_buf;
  logic        m_pend;
  logic        m_fd;

  function automatic logic ref_lit(int c, logic [15:0] d);
`ifdef LEADING_ZERO_BLANK_EN
    if (c > DP && (d >> (4 * c)) == 16'h0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
  endtask

  task automatic step();
    exp_t e;
    exp_t g;
    int   c;
    if (rst) begin
      m_cyc = 0; m_disp = '0; m_buf = '0; m_pend = 1'b0; m_fd = 1'b0;
    end else begin
      m_fd = ((m_cyc % 16) == 15);
      if (m_fd) begin
        if (load) m_disp = value_in;
        else if (m_pend) m_disp = m_buf;
        m_pend = 1'b0;
      end else if (load) begin
        m_buf  = value_in;
        m_pend = 1'b1;
      end
      m_cyc++;
    end
    c       = (m_cyc / DIV) % 4;
    e.cnt   = 2'(c);
    e.digit = 4'(m_disp >> (4 * c));
    e.an    = (enable && ref_lit(c, m_disp)) ? 4'(1 << c) : 4'b0000;
    e.point = enable && ref_lit(c, m_disp) && (c == DP);
    e.fd    = m_fd;
    e.pend  = m_pend;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk("sb_cnt", 32'(cnt), 32'(g.cnt));
    chk("sb_an", 32'(an), 32'(g.an));
    chk("sb_digit", 32'(digit), 32'(g.digit));
    chk("sb_point", 32'(point), 32'(g.point));
    chk("sb_frame_done", 32'(frame_done), 32'(g.fd));
    chk("sb_pending", 32'(pending), 32'(g.pend));
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic step_until(input int target);
    for (int i = 0; i < 1000 && m_cyc < target; i++) step();
    chk("step_until_reached", 32'(m_cyc), 32'(target));
  endtask

  initial begin
    vec_t tbl[8];
    int   n;
    tbl[0] = '{1'b1, 2'd0, 4'b0001, 4'h4, 1'b0};
    tbl[1] = '{1'b1, 2'd1, 4'b0010, 4'h3, 1'b1};
    tbl[2] = '{1'b1, 2'd2, 4'b0100, 4'h2, 1'b0};
    tbl[3] = '{1'b1, 2'd3, 4'b1000, 4'h1, 1'b0};
    tbl[4] = '{1'b0, 2'd0, 4'b0000, 4'h4, 1'b0};
    tbl[5] = '{1'b0, 2'd1, 4'b0000, 4'h3, 1'b0};
    tbl[6] = '{1'b0, 2'd2, 4'b0000, 4'h2, 1'b0};
    tbl[7] = '{1'b0, 2'd3, 4'b0000, 4'h1, 1'b0};

    rst = 1'b1; load = 1'b0; enable = 1'b1; value_in = '0;
    step();
    chk("reset_cnt", 32'(cnt), 0);
    chk("reset_an", 32'(an), 32'h1);
    chk("reset_digit", 32'(digit), 0);
    chk("reset_pending", 32'(pending), 0);
    step();
    rst = 1'b0;

    n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (frame_done) n++;
    end
    chk("frame_done_per_16", 32'(n), 1);

    step_until(21);
    load = 1'b1; value_in = 16'h1234;
    step();
    load = 1'b0;
    chk("midframe_pending", 32'(pending), 1);
    chk("midframe_digit_held", 32'(digit), 0);
    step_until(32);
    chk("after_wrap_pending", 32'(pending), 0);

    for (int i = 0; i < 8; i++) begin
      enable = tbl[i].en;
      #1;
      chk("tbl_cnt", 32'(cnt), 32'(tbl[i].cnt));
      chk("tbl_an", 32'(an), 32'(tbl[i].an));
      chk("tbl_digit", 32'(digit), 32'(tbl[i].digit));
      chk("tbl_point", 32'(point), 32'(tbl[i].point));
      step_n(DIV);
    end
    enable = 1'b1;

    step_until(66);
    load = 1'b1; value_in = 16'h1111;
    step();
    load = 1'b0;
    step_until(70);
    load = 1'b1; value_in = 16'h2222;
    step();
    load = 1'b0;
    step_until(79);
    chk("dbl_old_digit3", 32'(digit), 32'h1);
    chk("dbl_pending", 32'(pending), 1);
    step();
    chk("dbl_new_digit0", 32'(digit), 32'h2);
    chk("dbl_pending_clr", 32'(pending), 0);

    step_until(95);
    load = 1'b1; value_in = 16'h5678;
    step();
    load = 1'b0;
    chk("bnd_load_digit0", 32'(digit), 32'h8);
    chk("bnd_load_pending", 32'(pending), 0);
    chk("bnd_load_frame_done", 32'(frame_done), 1);

    step_until(100);
    load = 1'b1; value_in = 16'h9999;
    step();
    load = 1'b0;
    step_n(2);
    chk("pre_rst_pending", 32'(pending), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_cnt", 32'(cnt), 0);
    chk("midrst_digit", 32'(digit), 0);
    chk("midrst_pending", 32'(pending), 0);

    step_until(5);
    load = 1'b1; value_in = 16'h0012;
    step();
    load = 1'b0;
    step_until(16);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (an == 4'b0100 || an == 4'b1000) n++;
    end
`ifdef LEADING_ZERO_BLANK_EN
    chk("lzb_0012_high_lit", 32'(n), 0);
`else
    chk("lzb_0012_high_lit", 32'(n), 8);
`endif
    step_until(40);
    load = 1'b1; value_in = 16'h0000;
    step();
    load = 1'b0;
    step_until(48);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (an != 4'b0000) n++;
    end
`ifdef LEADING_ZERO_BLANK_EN
    chk("lzb_0000_lit_cycles", 32'(n), 8);
`else
    chk("lzb_0000_lit_cycles", 32'(n), 16);
`endif

    for (int i = 0; i < 300; i++) begin
      load     = ($urandom_range(0, 7) == 0);
      value_in = 16'($urandom);
      enable   = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_scheduler.md
Name: seg_scan_scheduler

Overview:
Time-multiplexing scheduler for the 4-digit seven-segment display. It divides the system clock into a digit-scan tick and runs the 2-bit digit pointer `cnt`. It double-buffers a 16-bit BCD value so that updates land only on frame boundaries, which prevents tearing. Per scan slot it presents the selected nibble, the one-hot anode enable and the decimal point to the downstream segment decoder.

Parameters:
- CLK_DIV, 100000: clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range ≥ 2.
- DP_DIGIT, 1: digit index (0..3) whose decimal point is lit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- value_in  in  16  BCD value; digit k = value_in[4k+3:4k], digit 0 is rightmost
- load  in  1  single-cycle strobe; captures value_in into the pending buffer
- enable  in  1  display enable; low forces AN and point to 0
- cnt  out  2  current digit pointer
- AN  out  4  one-hot anode enable, active-high, bit k = digit k
- digit  out  4  BCD nibble for the current slot
- point  out  1  decimal point, active-high
- frame_done  out  1  one-cycle pulse when cnt wraps 3→0
- pending  out  1  a loaded value is waiting for the next frame boundary

Behaviour:
- Reset (rst=1 at a clk edge), applied immediately even mid-frame:
  - prescaler=0, cnt=0, display register=0, pending buffer=0, pending=0, frame_done=0.
  - Outputs after reset: digit=0; AN=0001 and point=0 if enable=1, otherwise AN=0000 and point=0.
- Prescaler:
  - Counts 0..CLK_DIV-1, with width $clog2(CLK_DIV).
  - tick is asserted in the cycle where prescaler==CLK_DIV-1; the prescaler then returns to 0.
- Digit pointer:
  - cnt increments modulo 4 on tick.
  - Wrap 3→0 is the frame boundary; frame_done is registered and pulses high for the one cycle following the wrap edge.
- Double buffer:
  - load=1 with no boundary this cycle: pending buffer <= value_in, pending <= 1.
  - load=1 while pending=1: overwrite the buffer; pending stays 1; the last load wins.
  - Frame boundary with pending=1 and no load: display <= pending buffer, pending <= 0.
  - Frame boundary with load=1 in the same cycle: display <= value_in directly, pending <= 0. load has priority over the older buffered value.
  - Frame boundary with pending=0 and no load: display unchanged.
- Slot outputs (combinational from registered cnt/display, zero latency relative to cnt):
  - digit = display[4*cnt+3 : 4*cnt]
  - AN = enable ? (4'b0001 << cnt) : 4'b0000
  - point = enable & (cnt==DP_DIGIT)
- enable does not stall the prescaler or cnt; scanning continues while blanked.
- Non-BCD nibbles (A..F) pass through unmodified; decoding is the downstream decoder's job.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k is blanked (AN bit forced 0) when its nibble and all higher nibbles of the display register are 0 and k > DP_DIGIT.
  - Digits at or below DP_DIGIT are never blanked.
  - A blanked digit's point is 0.
  - Example: display=0x0012 with DP_DIGIT=1 lights digits 0 and 1 only.
- Undefined: all four digits are always scanned whenever enable=1.

Decomposition:
- Shared package seg_pkg:
  - constants NUM_DIGITS=4, DIGIT_W=4
  - typedef digit_sel_t (2-bit)
  - typedef bcd4_t (16-bit)
  - default CLK_DIV constant
- One natural sub-module: seg_prescaler. It holds the parameterized CLK_DIV counter emitting tick and is reused by other timing blocks. The buffer and output logic stay in the top level.

Test Plan:
1. Reset and prescaler: CLK_DIV=4, enable=1, no load → after rst, AN=0001; AN steps 0010, 0100, 1000, 0001 every 4 clks; frame_done pulses once per 16 clks.
2. Display ordering: load value_in=0x1234 mid-frame → pending=1 and digit outputs unchanged until the wrap. From the next frame, digit=4, 3, 2, 1 for cnt=0..3, point=1 only at cnt=1, and pending=0.
3. Double load: load 0x1111 then 0x2222 within one frame → the next frame shows 0x2222 only.
4. Load at the boundary: load 0x5678 in the exact cycle cnt wraps 3→0 → display=0x5678 immediately, pending=0.
5. Blanking and reset: enable=0 → AN=0000 and point=0 while cnt still advances. rst asserted mid-frame with pending=1 → cnt=0, display=0, pending=0 on the next cycle.
6. Leading-zero blanking (LEADING_ZERO_BLANK_EN defined): load 0x0012 → AN never shows 0100 or 1000; 0x0000 → digits 0 and 1 stay lit.
